vga_console_writer: RTL and testbench
=====================================

// Module: vga_console_writer
// PURPOSE
//  Bus-side initiator for the VGA text controller: consumes a byte stream (UART RX / CPU
//  console port) and turns it into write_op/bus_addr/bus_data cell writes, plus
//  VGA_OFFSET_REG writes for hardware scrolling. Tracks cursor, wraps lines, scrolls the
//  80x30 grid, clears screen. Lets the text display work without a CPU driver.
// PARAMETERS
//  HNUM        80               cells per row (VGA_BLOCK_HNUM)
//  VNUM        30               rows per screen (VGA_BLOCK_VNUM)
//  OFFSET_ADDR `VGA_OFFSET_REG  bus address of the controller row-offset register
// PORTS
//  clk_50M     in   1   system clock; all logic on posedge
//  rst_n       in   1   asynchronous reset, active-low
//  char_valid  in   1   input byte valid
//  char_data   in   8   input byte (ASCII)
//  char_ready  out  1   block can accept a byte this cycle
//  write_op    out  1   one-cycle write strobe to the VGA controller
//  bus_addr    out  32  cell index (row*HNUM+col) or OFFSET_ADDR
//  bus_data    out  32  ASCII code in [7:0] (zero-extended) or row offset
// BEHAVIOUR
//  Reset: write_op=0, bus_addr=0, bus_data=0, char_ready=0, col=0, row=0, top=0,
//   state=CLR_ALL. Reset mid-operation aborts any sequence; the full clear restarts.
//  State: top = physical row shown at screen row 0.
//   Cursor cell addr = ((top+row) mod VNUM)*HNUM + col. Mod by compare/subtract;
//   multiply by shift-add. No '*' or '%' on non-constants.
//  char_ready=1 only in IDLE. Handshake = char_valid & char_ready. Byte registered.
//   Strobe outputs are registered; write_op is low whenever no write is issued.
//  FSM states: IDLE, PUT, CLR_ROW, CLR_ALL, OFS.
//  IDLE, accepted byte:
//   0x20..0x7E -> PUT.
//   0x0A LF    -> col=0, advance row.
//   0x0D CR    -> col=0, stay IDLE.
//   0x08 BS    -> if col>0 then col-=1, then PUT with 0x20; col does not advance.
//              -> col==0 is ignored.
//   0x0C FF    -> CLR_ALL.
//   others     -> dropped, stay IDLE.
//  PUT: write_op=1, addr=cursor cell, data=byte.
//   Write appears 1 cycle after handshake; then IDLE, so 1 byte per 2 cycles.
//   After a printable char: if col==HNUM-1 then col=0 and advance row, else col+=1.
//  Advance row:
//   row<VNUM-1  -> row+=1, IDLE.
//   row==VNUM-1 -> scroll: row stays, go CLR_ROW.
//  CLR_ROW: HNUM back-to-back writes of 0x20 to physical row top, cols 0..HNUM-1.
//   Then OFS with top_next = (top==VNUM-1) ? 0 : top+1.
//  CLR_ALL: HNUM*VNUM back-to-back writes of 0x20 to addr 0..HNUM*VNUM-1.
//   Then OFS with top_next=0; col=row=0.
//  OFS: one write, addr=OFFSET_ADDR, data={24'b0, top_next}. top<=top_next, then IDLE.
//  Counter widths: clear index 12 bits (max 2399), col 7 bits, row/top 5 bits.
//  char_valid is ignored while not ready; no byte is lost if the source holds valid.
// STRUCTURE
//  Shared peripheral package / peripheral_defines.svh: Console_state_t enum;
//   ASCII_SPACE/LF/CR/BS/FF constants; VGA_BLOCK_HNUM/VNUM; VGA_OFFSET_REG.
//  Single module. Optional sub-module console_cell_addr: comb (top,row,col) -> cell index.
// TESTING
//  1 Release rst_n -> 2400 writes of 0x20 to addr 0..2399 on consecutive cycles.
//    -> then write addr=OFFSET_ADDR data=0; then char_ready=1.
//  2 Send 'A' (0x41) then 'B' -> writes (0,0x41), (1,0x42).
//    -> each write 1 cycle after handshake; char_ready low for 1 cycle per byte.
//  3 81 x 'x' -> write to addr 79 is followed by addr 80, so the wrap goes to row 1.
//  4 CR,LF then 'Z' -> write (80,0x5A); 0x07 (BEL) produces no write.
//  5 30 x LF from row 0 -> no writes until row 29 is reached.
//    Next LF -> 80 writes of 0x20 at addr 0..79, then offset write data=1.
//    Next 'Q' -> write addr 0 (physical row 0 = screen row 29).
//  6 'AB', BS -> write (1,0x20); next 'C' -> write (1,0x43).
//    Assert rst_n low during a CLR_ROW -> write_op=0 immediately; full clear restarts.

Source files
------------

// File: rtl/vga_console_writer_pkg.sv
// Shared console-writer definitions: grid geometry, control codes, FSM states and
// the write payload presented to the VGA text controller.
package vga_console_writer_pkg;

    localparam int unsigned VGA_BLOCK_HNUM = 80;
    localparam int unsigned VGA_BLOCK_VNUM = 30;
    localparam logic [31:0] VGA_OFFSET_REG = 32'h0000_1000;

    localparam int unsigned COL_W = 7;
    localparam int unsigned ROW_W = 5;
    localparam int unsigned IDX_W = 12;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_FF    = 8'h0C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT,
        ST_CLR_ROW,
        ST_CLR_ALL,
        ST_OFS
    } console_state_t;

    typedef struct packed {
        logic        write_op;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_wr_t;

endpackage

// File: rtl/vga_console_writer_cell_addr.sv
// Combinational cell index: ((top+row) mod VNUM)*HNUM + col, without multiplier/divider.
module vga_console_writer_cell_addr
    import vga_console_writer_pkg::*;
#(
    parameter int unsigned HNUM = VGA_BLOCK_HNUM,
    parameter int unsigned VNUM = VGA_BLOCK_VNUM
) (
    input  logic [ROW_W-1:0] top_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic [COL_W-1:0] col_i,
    output logic [IDX_W-1:0] addr_o
);

    logic [ROW_W:0]   sum;
    logic [ROW_W:0]   wrapped;
    logic [IDX_W-1:0] prod;

    // top and row are both < VNUM, so one conditional subtract is a full modulo
    always_comb begin
        sum     = {1'b0, top_i} + {1'b0, row_i};
        wrapped = (sum >= (ROW_W+1)'(VNUM)) ? sum - (ROW_W+1)'(VNUM) : sum;
        prod    = '0;
        for (int i = 0; i < int'(IDX_W); i++) begin
            if (HNUM[i]) begin
                prod = prod + (IDX_W'(wrapped[ROW_W-1:0]) << i);
            end
        end
        addr_o = prod + IDX_W'(col_i);
    end

endmodule

// File: rtl/vga_console_writer.sv
// Byte-stream console front end: turns ASCII input into VGA text-cell writes,
// handling cursor, line wrap, hardware scroll via the row-offset register, and clear.
module vga_console_writer
    import vga_console_writer_pkg::*;
#(
    parameter int unsigned HNUM        = VGA_BLOCK_HNUM,
    parameter int unsigned VNUM        = VGA_BLOCK_VNUM,
    parameter logic [31:0] OFFSET_ADDR = VGA_OFFSET_REG
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        write_op,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data
);

    localparam int unsigned CELLS = HNUM * VNUM;

    console_state_t   state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] top_q, top_d;
    logic [ROW_W-1:0] ofs_top_q, ofs_top_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             adv_q, adv_d;
    logic             char_ready_q, char_ready_d;
    bus_wr_t          bus_q, bus_d;

    logic [IDX_W-1:0] cur_addr;
    logic [IDX_W-1:0] clr_addr;
    logic             adv_row;
    logic             accept;

    vga_console_writer_cell_addr #(.HNUM(HNUM), .VNUM(VNUM)) u_cur_addr (
        .top_i  (top_q),
        .row_i  (row_q),
        .col_i  (col_q),
        .addr_o (cur_addr)
    );

    // physical row 'top' is the row that scrolls off and gets blanked
    vga_console_writer_cell_addr #(.HNUM(HNUM), .VNUM(VNUM)) u_clr_addr (
        .top_i  (top_q),
        .row_i  ('0),
        .col_i  (idx_q[COL_W-1:0]),
        .addr_o (clr_addr)
    );

    assign accept = char_valid & char_ready_q;

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        top_d         = top_q;
        ofs_top_d     = ofs_top_q;
        idx_d         = idx_q;
        byte_d        = byte_q;
        adv_d         = adv_q;
        bus_d         = bus_q;
        bus_d.write_op = 1'b0;
        adv_row       = 1'b0;
        char_ready_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (char_data >= ASCII_SPACE && char_data <= ASCII_TILDE) begin
                        byte_d  = char_data;
                        adv_d   = 1'b1;
                        state_d = ST_PUT;
                    end else if (char_data == ASCII_LF) begin
                        col_d   = '0;
                        adv_row = 1'b1;
                    end else if (char_data == ASCII_CR) begin
                        col_d = '0;
                    end else if (char_data == ASCII_BS) begin
                        if (col_q != '0) begin
                            col_d   = col_q - COL_W'(1);
                            byte_d  = ASCII_SPACE;
                            adv_d   = 1'b0;
                            state_d = ST_PUT;
                        end
                    end else if (char_data == ASCII_FF) begin
                        idx_d   = '0;
                        state_d = ST_CLR_ALL;
                    end
                end
            end
            ST_PUT: begin
                bus_d.write_op = 1'b1;
                bus_d.addr     = 32'(cur_addr);
                bus_d.data     = 32'(byte_q);
                state_d        = ST_IDLE;
                if (adv_q) begin
                    if (col_q == COL_W'(HNUM - 1)) begin
                        col_d   = '0;
                        adv_row = 1'b1;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_CLR_ROW: begin
                bus_d.write_op = 1'b1;
                bus_d.addr     = 32'(clr_addr);
                bus_d.data     = 32'(ASCII_SPACE);
                idx_d          = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(HNUM - 1)) begin
                    ofs_top_d = (top_q == ROW_W'(VNUM - 1)) ? '0 : top_q + ROW_W'(1);
                    state_d   = ST_OFS;
                end
            end
            ST_CLR_ALL: begin
                bus_d.write_op = 1'b1;
                bus_d.addr     = 32'(idx_q);
                bus_d.data     = 32'(ASCII_SPACE);
                idx_d          = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(CELLS - 1)) begin
                    ofs_top_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                    state_d   = ST_OFS;
                end
            end
            ST_OFS: begin
                bus_d.write_op = 1'b1;
                bus_d.addr     = OFFSET_ADDR;
                bus_d.data     = 32'(ofs_top_q);
                top_d          = ofs_top_q;
                state_d        = ST_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = ST_CLR_ALL;
            end
        endcase

        // on the last row a new line scrolls instead of moving the cursor
        if (adv_row) begin
            if (row_q < ROW_W'(VNUM - 1)) begin
                row_d = row_q + ROW_W'(1);
            end else begin
                idx_d   = '0;
                state_d = ST_CLR_ROW;
            end
        end

        char_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLR_ALL;
            col_q        <= '0;
            row_q        <= '0;
            top_q        <= '0;
            ofs_top_q    <= '0;
            idx_q        <= '0;
            byte_q       <= '0;
            adv_q        <= 1'b0;
            char_ready_q <= 1'b0;
            bus_q        <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            top_q        <= top_d;
            ofs_top_q    <= ofs_top_d;
            idx_q        <= idx_d;
            byte_q       <= byte_d;
            adv_q        <= adv_d;
            char_ready_q <= char_ready_d;
            bus_q        <= bus_d;
        end
    end

    assign char_ready = char_ready_q;
    assign write_op   = bus_q.write_op;
    assign bus_addr   = bus_q.addr;
    assign bus_data   = bus_q.data;

endmodule

// File: tb/tb_vga_console_writer.sv
// Self-checking bench for vga_console_writer: directed vectors, scroll/clear sequences
// and a randomized byte stream checked against a cursor/screen reference model.
module tb_vga_console_writer;
    import vga_console_writer_pkg::*;

    localparam int H = 80;
    localparam int V = 30;

    logic        clk_50M = 1'b0;
    logic        rst_n;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        write_op;
    logic [31:0] bus_addr;
    logic [31:0] bus_data;

    always #10 clk_50M = ~clk_50M;

    vga_console_writer dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .write_op   (write_op),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data)
    );

    int checks = 0;
    int errors = 0;

    bit          mon_en = 1'b0;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    int          m_col, m_row, m_top;

    typedef struct {
        logic [7:0] ch;
        bit         we;
        int         addr;
        logic [7:0] data;
    } vec_t;
    vec_t tbl[15];

    always @(negedge clk_50M) begin
        if (mon_en && write_op) got_q.push_back({bus_addr, bus_data});
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (!char_ready && n < limit) begin
            @(negedge clk_50M);
            n++;
        end
        if (!char_ready) chk("ready_timeout", 96'(char_ready), 96'(1));
    endtask

    // drive one byte, leave at the negedge after the handshake edge
    task automatic send_raw(input logic [7:0] b);
        wait_ready(6000);
        char_valid = 1'b1;
        char_data  = b;
        @(negedge clk_50M);
        char_valid = 1'b0;
    endtask

    task automatic send_chk(input logic [7:0] b, input bit we, input int addr,
                            input logic [7:0] data, input string name);
        send_raw(b);
        chk({name, " ready"}, 96'(char_ready), 96'(!we));
        @(negedge clk_50M);
        chk({name, " we"}, 96'(write_op), 96'(we));
        if (we) begin
            chk({name, " addr"}, 96'(bus_addr), 96'(addr));
            chk({name, " data"}, 96'(bus_data), 96'(data));
        end
    endtask

    task automatic expect_clear(input int base, input int n, input int ofs, input string name);
        int w = 0;
        int bad = 0;
        while (!write_op && w < 100) begin
            @(negedge clk_50M);
            w++;
        end
        chk({name, " start"}, 96'(write_op), 96'(1));
        for (int i = 0; i < n; i++) begin
            if (!(write_op === 1'b1 && bus_addr == 32'(base + i) && bus_data == 32'h20)) bad++;
            @(negedge clk_50M);
        end
        chk({name, " cells"}, 96'(bad), 96'(0));
        chk({name, " ofs addr"}, {63'(write_op), bus_addr}, {63'(1), VGA_OFFSET_REG});
        chk({name, " ofs data"}, 96'(bus_data), 96'(ofs));
        @(negedge clk_50M);
        chk({name, " idle"}, 96'({write_op, char_ready}), 96'(2'b01));
    endtask

    function automatic logic [31:0] m_cell();
        return 32'(((m_top + m_row) % V) * H + m_col);
    endfunction

    task automatic m_adv();
        if (m_row < V - 1) begin
            m_row++;
        end else begin
            for (int c = 0; c < H; c++) exp_q.push_back({32'(m_top * H + c), 32'h20});
            m_top = (m_top + 1) % V;
            exp_q.push_back({VGA_OFFSET_REG, 32'(m_top)});
        end
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({m_cell(), 32'(b)});
            m_col++;
            if (m_col == H) begin
                m_col = 0;
                m_adv();
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            m_adv();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_q.push_back({m_cell(), 32'h20});
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        int         r;
        int         nmin;

        tbl[0]  = '{8'h41, 1'b1, 0,  8'h41};
        tbl[1]  = '{8'h42, 1'b1, 1,  8'h42};
        tbl[2]  = '{8'h08, 1'b1, 1,  8'h20};
        tbl[3]  = '{8'h43, 1'b1, 1,  8'h43};
        tbl[4]  = '{8'h0D, 1'b0, 0,  8'h00};
        tbl[5]  = '{8'h0A, 1'b0, 0,  8'h00};
        tbl[6]  = '{8'h5A, 1'b1, 80, 8'h5A};
        tbl[7]  = '{8'h07, 1'b0, 0,  8'h00};
        tbl[8]  = '{8'h7E, 1'b1, 81, 8'h7E};
        tbl[9]  = '{8'h7F, 1'b0, 0,  8'h00};
        tbl[10] = '{8'h1F, 1'b0, 0,  8'h00};
        tbl[11] = '{8'h08, 1'b1, 81, 8'h20};
        tbl[12] = '{8'h0D, 1'b0, 0,  8'h00};
        tbl[13] = '{8'h08, 1'b0, 0,  8'h00};
        tbl[14] = '{8'h20, 1'b1, 80, 8'h20};

        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        repeat (3) @(negedge clk_50M);
        chk("rst write_op", 96'(write_op), 96'(0));
        chk("rst bus_addr", 96'(bus_addr), 96'(0));
        chk("rst bus_data", 96'(bus_data), 96'(0));
        chk("rst char_ready", 96'(char_ready), 96'(0));
        rst_n = 1'b1;
        expect_clear(0, H * V, 0, "init clear");

        for (int i = 0; i < 15; i++) begin
            send_chk(tbl[i].ch, tbl[i].we, tbl[i].addr, tbl[i].data, $sformatf("vec%0d", i));
        end

        // valid held high across the busy cycle: second byte must wait, not be lost
        wait_ready(10);
        char_valid = 1'b1;
        char_data  = 8'h41;
        @(negedge clk_50M);
        chk("held busy", 96'(char_ready), 96'(0));
        char_data = 8'h42;
        @(negedge clk_50M);
        chk("held A", {31'(write_op), bus_addr, bus_data}, {31'(1), 32'd81, 32'h41});
        chk("held ready", 96'(char_ready), 96'(1));
        @(negedge clk_50M);
        char_valid = 1'b0;
        chk("held B busy", 96'(char_ready), 96'(0));
        @(negedge clk_50M);
        chk("held B", {31'(write_op), bus_addr, bus_data}, {31'(1), 32'd82, 32'h42});

        send_raw(8'h0C);
        expect_clear(0, H * V, 0, "ff clear");
        for (int i = 0; i < 81; i++) begin
            send_chk(8'h78, 1'b1, i, 8'h78, $sformatf("wrap x%0d", i));
        end

        send_raw(8'h0C);
        expect_clear(0, H * V, 0, "ff clear2");
        for (int i = 0; i < V - 1; i++) begin
            send_chk(8'h0A, 1'b0, 0, 8'h00, $sformatf("lf%0d", i));
        end
        send_raw(8'h0A);
        expect_clear(0, H, 1, "scroll0");
        send_chk(8'h51, 1'b1, 0, 8'h51, "Q after scroll");
        for (int k = 1; k < V; k++) begin
            send_raw(8'h0A);
            expect_clear(k * H, H, (k + 1) % V, $sformatf("scroll%0d", k));
        end
        send_chk(8'h52, 1'b1, (V - 1) * H, 8'h52, "R after top wrap");

        // reset in the middle of a row clear
        send_raw(8'h0A);
        r = 0;
        while (!write_op && r < 100) begin
            @(negedge clk_50M);
            r++;
        end
        repeat (5) @(negedge clk_50M);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst write_op", 96'(write_op), 96'(0));
        chk("midrst ready", 96'(char_ready), 96'(0));
        @(negedge clk_50M);
        rst_n = 1'b1;
        expect_clear(0, H * V, 0, "midrst clear");

        m_col = 0;
        m_row = 0;
        m_top = 0;
        got_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk_50M);
            r = $urandom_range(0, 99);
            if (r < 60)      b = 8'($urandom_range(32, 126));
            else if (r < 72) b = 8'h0A;
            else if (r < 78) b = 8'h0D;
            else if (r < 86) b = 8'h08;
            else begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h0C) b = 8'h07;
            end
            m_byte(b);
            send_raw(b);
        end
        wait_ready(2000);
        repeat (4) @(negedge clk_50M);
        mon_en = 1'b0;
        chk("rand count", 96'(got_q.size()), 96'(exp_q.size()));
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            chk($sformatf("rand write%0d", i), 96'(got_q[i]), 96'(exp_q[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
